// File: rtl/dlm_pkg.sv
// Shared types and helpers for the persisted-deadlock monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dlm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SUSPECT = 2'd1,
      BLOCKED = 2'd2
   } dlm_state_e;

   localparam logic [1:0] SRC_AXIS = 2'b01;
   localparam logic [1:0] SRC_INST = 2'b10;
   localparam logic [1:0] SRC_BOTH = 2'b11;

   // Bits needed to index n items, never less than one bit.
   function automatic int dlm_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Port width for vectors whose element count may legally be zero.
   function automatic int dlm_max1(input int n);
      return (n > 0) ? n : 1;
   endfunction

endpackage

// File: rtl/dlm_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set request bit.
// Latency: combinational.
// Backpressure: none.
// Ports: req - request vector; id - lowest set index (0 when none); vld - any bit set.
module dlm_prio_enc #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   output logic [ID_W-1:0] id,
   output logic            vld
);

   // Scan from the top down so the lowest set bit is the last writer.
   always_comb begin
      id  = '0;
      vld = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            id  = ID_W'(i);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/deadlock_persist_monitor.sv
// Deadlock monitor: raises block once an axis stall or all-instances-stuck condition persists PERSIST_CYCLES cycles.
// Latency: block rises one edge after the PERSIST_CYCLES-th consecutive raw sample, falls one edge after raw drops.
// Backpressure: none; observe-only, never stalls the watched paths.
// Ports: clock/reset_n (sync, active-low); axis_block_sigs, inst_idle_sigs, inst_block_sigs raw flags;
//        clear wipes diagnosis; block, block_sticky, first_axis_id, first_src, block_events status outputs.
module deadlock_persist_monitor
   import dlm_pkg::*;
#(
   parameter int NUM_AXIS       = 4,
   parameter int NUM_INST       = 1,
   parameter int PERSIST_CYCLES = 1,
   parameter int CNT_W          = 8,
   parameter int ID_W           = dlm_width(NUM_AXIS)
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_AXIS-1:0]           axis_block_sigs,
   input  logic [dlm_max1(NUM_INST)-1:0] inst_idle_sigs,
   input  logic [dlm_max1(NUM_INST)-1:0] inst_block_sigs,
   input  logic                          clear,
   output logic                          block,
   output logic                          block_sticky,
   output logic [ID_W-1:0]               first_axis_id,
   output logic [1:0]                    first_src,
   output logic [CNT_W-1:0]              block_events
);

   localparam int              PC_W    = dlm_width(PERSIST_CYCLES + 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERSIST_CYCLES - 1);

   logic            axis_any;
   logic [ID_W-1:0] axis_id;
   logic            inst_all;
   logic            raw;
   logic            entry;

   dlm_state_e      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            block_q;
   logic            sticky_q, sticky_d;
   logic [ID_W-1:0] first_id_q, first_id_d;
   logic [1:0]      first_src_q, first_src_d;
   logic [CNT_W-1:0] events_q, events_d;

   dlm_prio_enc #(
      .N    (NUM_AXIS),
      .ID_W (ID_W)
   ) u_prio_enc (
      .req (axis_block_sigs),
      .id  (axis_id),
      .vld (axis_any)
   );

   // Instances count as stuck only when every one is blocked or idle and at
   // least one is actually blocked; an all-idle design is simply quiescent.
   generate
      if (NUM_INST > 0) begin : g_inst
         assign inst_all = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);
      end else begin : g_no_inst
         logic unused_inst;
         assign unused_inst = ^{inst_idle_sigs, inst_block_sigs};
         assign inst_all    = 1'b0;
      end
   endgenerate

   assign raw = axis_any | inst_all;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: begin
            if (raw) begin
               if (PERSIST_CYCLES == 1) begin
                  state_d = BLOCKED;
               end else begin
                  state_d = SUSPECT;
                  pc_d    = PC_W'(1);
               end
            end
         end
         SUSPECT: begin
            if (!raw) begin
               state_d = IDLE;
               pc_d    = '0;
            end else if (pc_q == PC_LAST) begin
               state_d = BLOCKED;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         BLOCKED: begin
            if (!raw) begin
               state_d = IDLE;
               pc_d    = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
         end
      endcase
   end

   assign entry = (state_q != BLOCKED) && (state_d == BLOCKED);

   // Clear is applied first so that an entry on the same edge re-arms the
   // capture and restarts the event count at one.
   always_comb begin
      sticky_d    = sticky_q;
      first_id_d  = first_id_q;
      first_src_d = first_src_q;
      events_d    = events_q;
      if (clear) begin
         sticky_d    = 1'b0;
         first_id_d  = '0;
         first_src_d = '0;
         events_d    = '0;
      end
      if (entry) begin
         if (!sticky_d) begin
            first_id_d  = axis_id;
            first_src_d = (axis_any && inst_all) ? SRC_BOTH :
                          inst_all               ? SRC_INST : SRC_AXIS;
         end
         sticky_d = 1'b1;
         if (events_d != {CNT_W{1'b1}}) begin
            events_d = events_d + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         block_q     <= 1'b0;
         sticky_q    <= 1'b0;
         first_id_q  <= '0;
         first_src_q <= '0;
         events_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         block_q     <= (state_d == BLOCKED);
         sticky_q    <= sticky_d;
         first_id_q  <= first_id_d;
         first_src_q <= first_src_d;
         events_q    <= events_d;
      end
   end

   assign block         = block_q;
   assign block_sticky  = sticky_q;
   assign first_axis_id = first_id_q;
   assign first_src     = first_src_q;
   assign block_events  = events_q;

endmodule
